// File: rtl/tdpr_fifo_ctrl_pkg.sv
// Shared sizing for the dual-port-RAM FIFO controller.
// Default widths, the storage depth helper and the output buffer depth.
package tdpr_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int DATA_SIZE_DEF = 8;
    localparam int OUT_BUF_DEPTH = 2;

    function automatic int depth(input int addr_size);
        return 1 << addr_size;
    endfunction

endpackage

// File: rtl/tdpr_fifo_ctrl_if.sv
// Write stream, read stream and RAM port signals of the FIFO controller.
// Handshakes: a word moves on a cycle where valid & ready are both high at the rising edge;
// valid never depends on ready, and ready never depends on valid.
interface tdpr_fifo_ctrl_if
    import tdpr_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [DATA_SIZE-1:0]   wr_data;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [DATA_SIZE-1:0]   rd_data;
    logic [ADDR_SIZE+1:0]   level;
    logic                   en_a;
    logic                   we_a;
    logic [ADDR_SIZE-1:0]   addr_a;
    logic [DATA_SIZE-1:0]   din_a;
    logic                   en_b;
    logic                   we_b;
    logic [ADDR_SIZE-1:0]   addr_b;
    logic [DATA_SIZE-1:0]   dout_b;

    modport slave (
        input  wr_valid, wr_data, rd_ready, dout_b,
        output wr_ready, rd_valid, rd_data, level,
               en_a, we_a, addr_a, din_a, en_b, we_b, addr_b
    );

    modport master (
        output wr_valid, wr_data, rd_ready, dout_b,
        input  wr_ready, rd_valid, rd_data, level,
               en_a, we_a, addr_a, din_a, en_b, we_b, addr_b
    );

endinterface

// File: rtl/tdpr_fifo_ctrl_out_buf.sv
// Two-entry register FIFO that catches words landing from RAM port B.
// The caller guarantees no push into a full buffer unless it also pops.
module tdpr_out_buf
    import tdpr_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic [1:0]           count_o
);
    logic [DATA_SIZE-1:0] mem_q [OUT_BUF_DEPTH];
    logic                 head_q, head_d;
    logic [1:0]           count_q, count_d;
    logic                 tail;

    // With two slots the tail is the head when empty or full, the other slot otherwise.
    assign tail    = head_q ^ count_q[0];
    assign data_o  = mem_q[head_q];
    assign count_o = count_q;

    always_comb begin
        head_d  = head_q ^ pop_i;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail] <= data_i;
        end
    end

endmodule

// File: rtl/tdpr_fifo_ctrl.sv
// FIFO controller using an external true dual-port RAM: port A writes, port B reads,
// and a 2-entry output buffer hides the RAM's one-cycle read latency.
module tdpr_fifo_ctrl
    import tdpr_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    tdpr_fifo_ctrl_if.slave  bus
);
    localparam int                 DEPTH = depth(ADDR_SIZE);
    localparam logic [ADDR_SIZE:0] FULL  = (ADDR_SIZE+1)'(DEPTH);

    logic [ADDR_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0] rptr_q, rptr_d;
    logic [ADDR_SIZE:0]   mem_count_q, mem_count_d;
    logic                 inflight_q;
    logic [1:0]           buf_count;
    logic [2:0]           occ;
    logic                 active, push, pop, issue, buf_room;

    // Reset and flush suppress all RAM traffic in the cycle they are asserted.
    assign active = rst_n & ~flush;

    assign bus.wr_ready = (mem_count_q != FULL);
    assign push         = active & bus.wr_valid & bus.wr_ready;
    assign bus.rd_valid = (buf_count != 2'd0);
    assign pop          = active & bus.rd_valid & bus.rd_ready;

    // Issue only if the word would still fit once it lands next cycle.
    always_comb begin
        occ      = {1'b0, buf_count} + {2'b0, inflight_q};
        buf_room = (occ - {2'b0, pop}) <= 3'd1;
    end
    assign issue = active & (mem_count_q != '0) & buf_room;

    assign bus.en_a   = push;
    assign bus.we_a   = push;
    assign bus.addr_a = wptr_q;
    assign bus.din_a  = bus.wr_data;
    assign bus.en_b   = issue;
    assign bus.we_b   = 1'b0;
    assign bus.addr_b = rptr_q;

    assign bus.level = (ADDR_SIZE+2)'(mem_count_q) + (ADDR_SIZE+2)'(inflight_q)
                     + (ADDR_SIZE+2)'(buf_count);

    always_comb begin
        wptr_d      = wptr_q + ADDR_SIZE'(push);
        rptr_d      = rptr_q + ADDR_SIZE'(issue);
        mem_count_d = mem_count_q + (ADDR_SIZE+1)'(push) - (ADDR_SIZE+1)'(issue);
    end

    always_ff @(posedge clk) begin
        if (!active) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_count_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_count_q <= mem_count_d;
            inflight_q  <= issue;
        end
    end

    tdpr_out_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .data_i  (bus.dout_b),
        .data_o  (bus.rd_data),
        .count_o (buf_count)
    );

endmodule

// File: tb/tb_tdpr_fifo_ctrl.sv
// Directed bench for tdpr_fifo_ctrl with a small behavioural dual-port RAM (16 words).
module tb_tdpr_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    logic flush;

    tdpr_fifo_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    tdpr_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model ----------------
    logic [DW-1:0] ram [1<<AW];
    logic [DW-1:0] ram_rd_q;
    logic          ram_rv_q;

    always @(posedge clk) begin
        if (bus.en_a && bus.we_a) ram[bus.addr_a] <= bus.din_a;
        if (bus.en_b) ram_rd_q <= ram[bus.addr_b];
        ram_rv_q <= bus.en_b;
    end
    // Marker value when no read is pending, so stale sampling shows up.
    assign bus.dout_b = ram_rv_q ? ram_rd_q : 8'hEE;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc = 0, push_cnt, pop_cnt, first_wr, first_pop, last_pop, coll_cnt;
    int last_a, last_b;
    bit saw_a_wrap, saw_b_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic reset_stats();
        push_cnt = 0; pop_cnt = 0; first_wr = -1; first_pop = -1; last_pop = -1;
        coll_cnt = 0; last_a = -1; last_b = -1; saw_a_wrap = 0; saw_b_wrap = 0;
    endtask

    task automatic mon();
        logic [DW-1:0] e;
        cyc++;
        if (bus.en_a && bus.en_b && bus.addr_a == bus.addr_b) coll_cnt++;
        if (bus.en_a) begin
            if (bus.addr_a == 0 && last_a == 15) saw_a_wrap = 1;
            last_a = int'(bus.addr_a);
        end
        if (bus.en_b) begin
            if (bus.addr_b == 0 && last_b == 15) saw_b_wrap = 1;
            last_b = int'(bus.addr_b);
        end
        if (u_dut.inflight_q && u_dut.u_buf.count_q == 2'd2 && !(bus.rd_valid && bus.rd_ready))
            check("buf_ovf", 32'd1, 32'd0);
        if (rst_n && !flush && bus.wr_valid && bus.wr_ready) begin
            exp_q.push_back(bus.wr_data);
            push_cnt++;
            if (first_wr < 0) first_wr = cyc;
        end
        if (rst_n && !flush && bus.rd_valid && bus.rd_ready) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (exp_q.size() == 0) check("pop_empty", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(e));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && exp_q.size() != 0; k++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        reset_stats();
        @(posedge clk); #1;
        step();
        // Reset held with a write request: no RAM activity, state cleared.
        bus.wr_valid = 1'b1; bus.wr_data = 8'h77;
        half();
        check("rst_en_a", 32'(bus.en_a), 32'd0);
        check("rst_en_b", 32'(bus.en_b), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        fin();
        bus.wr_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // 1: single word latency
        reset_stats();
        bus.wr_valid = 1'b1; bus.wr_data = 8'hA5; bus.rd_ready = 1'b1;
        half();
        check("t1_en_a", 32'(bus.en_a), 32'd1);
        check("t1_addr_a", 32'(bus.addr_a), 32'd0);
        check("t1_din_a", 32'(bus.din_a), 32'hA5);
        check("t1_en_b0", 32'(bus.en_b), 32'd0);
        fin();
        bus.wr_valid = 1'b0;
        half();
        check("t1_en_b", 32'(bus.en_b), 32'd1);
        check("t1_addr_b", 32'(bus.addr_b), 32'd0);
        check("t1_level1", 32'(bus.level), 32'd1);
        fin();
        half();
        check("t1_rv2", 32'(bus.rd_valid), 32'd0);
        check("t1_level2", 32'(bus.level), 32'd1);
        fin();
        half();
        check("t1_rv3", 32'(bus.rd_valid), 32'd1);
        check("t1_level3", 32'(bus.level), 32'd1);
        fin();
        half();
        check("t1_level4", 32'(bus.level), 32'd0);
        check("t1_rv4", 32'(bus.rd_valid), 32'd0);
        fin();

        // 2: back-to-back stream of 64 words
        reset_stats();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = 8'(i);
            step();
        end
        bus.wr_valid = 1'b0;
        drain(20);
        check("t2_left", exp_q.size(), 0);
        check("t2_pops", pop_cnt, 64);
        check("t2_span", last_pop - first_pop, 63);
        check("t2_latency", first_pop - first_wr, 3);

        // 3: fill with no reads
        reset_stats();
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bit full;
            bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h40 + k);
            half();
            full = !bus.wr_ready;
            fin();
            if (full) break;
        end
        bus.wr_valid = 1'b0;
        check("t3_accepted", push_cnt, 18);
        half();
        check("t3_level_full", 32'(bus.level), 32'd18);
        check("t3_wr_ready0", 32'(bus.wr_ready), 32'd0);
        fin();
        bus.rd_ready = 1'b1;
        half();
        check("t3_pop_rv", 32'(bus.rd_valid), 32'd1);
        check("t3_pop_wr_ready", 32'(bus.wr_ready), 32'd0);
        fin();
        bus.rd_ready = 1'b0;
        half();
        check("t3_wr_ready1", 32'(bus.wr_ready), 32'd1);
        check("t3_level17", 32'(bus.level), 32'd17);
        fin();
        bus.rd_ready = 1'b1;
        drain(40);
        check("t3_left", exp_q.size(), 0);
        check("t3_pops", pop_cnt, 18);

        // 4: pointer wrap with random back-pressure
        reset_stats();
        for (int k = 0; k < 300 && push_cnt < 40; k++) begin
            bus.rd_ready = 1'($urandom_range(0, 1));
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'h80 + push_cnt);
            step();
        end
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
        drain(40);
        check("t4_pushes", push_cnt, 40);
        check("t4_left", exp_q.size(), 0);
        check("t4_pops", pop_cnt, 40);
        check("t4_a_wrap", 32'(saw_a_wrap), 32'd1);
        check("t4_b_wrap", 32'(saw_b_wrap), 32'd1);
        check("t4_collide", coll_cnt, 0);

        // 5: flush while a read is in flight
        reset_stats();
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h11 + i);
            step();
        end
        flush = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'h14;
        half();
        check("t5_pre_level", 32'(bus.level), 32'd3);
        check("t5_inflight", 32'(u_dut.inflight_q), 32'd1);
        check("t5_fl_en_a", 32'(bus.en_a), 32'd0);
        check("t5_fl_en_b", 32'(bus.en_b), 32'd0);
        fin();
        exp_q.delete();
        flush = 1'b0; bus.wr_valid = 1'b0;
        half();
        check("t5_rv", 32'(bus.rd_valid), 32'd0);
        check("t5_level", 32'(bus.level), 32'd0);
        fin();
        half();
        check("t5_rv_b", 32'(bus.rd_valid), 32'd0);
        fin();
        bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
        half();
        check("t5_addr_a", 32'(bus.addr_a), 32'd0);
        fin();
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
        drain(10);
        check("t5_left", exp_q.size(), 0);
        check("t5_pops", pop_cnt, 1);

        // 6: reset pulse mid-stream
        reset_stats();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h61 + i);
            step();
        end
        rst_n = 1'b0; bus.wr_data = 8'h99;
        half();
        check("t6_en_a", 32'(bus.en_a), 32'd0);
        check("t6_en_b", 32'(bus.en_b), 32'd0);
        fin();
        exp_q.delete();
        rst_n = 1'b1; bus.wr_valid = 1'b0;
        half();
        check("t6_level", 32'(bus.level), 32'd0);
        check("t6_rv", 32'(bus.rd_valid), 32'd0);
        check("t6_wr_ready", 32'(bus.wr_ready), 32'd1);
        fin();
        bus.wr_valid = 1'b1; bus.wr_data = 8'h5A;
        step();
        bus.wr_valid = 1'b0;
        drain(10);
        check("t6_left", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
